cos_req_scheduler: RTL and testbench

- Shares one cosine datapath between NREQ requesters: IEEE-754 single-precision theta in, unsigned Q2.30 cos(theta) out.
- Round-robin arbitration over valid/ready request channels.
- Holds the core input stable for a parameterised settle/pipeline latency, captures the result and returns it to the winning requester.
- Rejects out-of-range theta (|theta| > 1.0, Inf, NaN) without using the core.

---
 rtl/cordic_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/cos_req_scheduler.sv | 118 +++++++++++
 tb/tb_cos_req_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the cosine request scheduler: FSM states,
// IEEE-754 single-precision field layout and Q2.30 constants.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
    localparam int unsigned FP_EXP_BIAS = 127;

    localparam int unsigned FP_SIGN_BIT = 31;
    localparam int unsigned FP_EXP_MSB  = 30;
    localparam int unsigned FP_EXP_LSB  = 23;
    localparam int unsigned FP_MAN_MSB  = 22;
    localparam int unsigned FP_MAN_LSB  = 0;

    localparam logic [31:0] ONE_Q230 = 32'h4000_0000;

    // |theta| > 1.0 in float terms; Inf and NaN land here via the all-ones exponent.
    function automatic logic theta_out_of_range(input logic [31:0] theta);
        logic [7:0]  expo;
        logic [22:0] mant;
        expo = theta[FP_EXP_MSB:FP_EXP_LSB];
        mant = theta[FP_MAN_MSB:FP_MAN_LSB];
        return (expo > 8'(FP_EXP_BIAS)) || ((expo == 8'(FP_EXP_BIAS)) && (mant != '0));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid bit at or above ptr, with
// wrap-around. The pointer itself is owned by the caller.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any
);

    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any && valid[idx]) begin
                any            = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/cos_req_scheduler.sv
// Shares one cosine core among NREQ valid/ready requesters with round-robin
// arbitration, a fixed settle window and range rejection of theta.
module cos_req_scheduler
    import cordic_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned LATENCY = 0,
    parameter int unsigned CW      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_theta,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_result,
    output logic                 resp_err,
    output logic [31:0]          cos_theta,
    input  logic [31:0]          cos_result,
    output logic                 busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t    state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   id;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            gany;
    logic [31:0]     gtheta;
    logic            gerr;
    logic [31:0]     theta_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_theta
        assign theta_arr[g] = req_theta[32*g +: 32];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (gidx),
        .any       (gany)
    );

    always_comb begin
        gtheta = theta_arr[gidx];
        gerr   = theta_out_of_range(gtheta);
    end

    // Grant is only offered while idle, so any grant in IDLE is a completed handshake.
    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            id          <= '0;
            cnt         <= '0;
            cos_theta   <= '0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            resp_valid  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gany) begin
                        id  <= gidx;
                        ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                        if (gerr) begin
                            resp_result <= '0;
                            resp_err    <= 1'b1;
                            resp_valid  <= onehot(gidx);
                            state       <= RESP;
                        end else begin
                            cos_theta <= gtheta;
                            cnt       <= CW'(LATENCY);
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        resp_result <= cos_result;
                        resp_err    <= 1'b0;
                        resp_valid  <= onehot(id);
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready[id]) begin
                        resp_valid <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cos_req_scheduler.sv
// Bench for cos_req_scheduler: two instances (LATENCY 0 and 3), a stub core
// that only returns a valid value once its input has been stable long enough.
module tb_cos_req_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  rv  [2];
    logic [1:0]  rdy [2];
    logic [1:0]  rsv [2];
    logic [1:0]  rr  [2];
    logic [63:0] rth [2];
    logic [31:0] res [2];
    logic [31:0] ct  [2];
    logic [31:0] cr  [2];
    logic        err [2];
    logic        bsy [2];

    int checks = 0;
    int errors = 0;

    cos_req_scheduler #(.NREQ(2), .LATENCY(0), .CW(3)) dut0 (
        .clk(clk), .reset(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_theta(rth[0]),
        .resp_valid(rsv[0]), .resp_ready(rr[0]), .resp_result(res[0]), .resp_err(err[0]),
        .cos_theta(ct[0]), .cos_result(cr[0]), .busy(bsy[0]));

    cos_req_scheduler #(.NREQ(2), .LATENCY(3), .CW(3)) dut1 (
        .clk(clk), .reset(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_theta(rth[1]),
        .resp_valid(rsv[1]), .resp_ready(rr[1]), .resp_result(res[1]), .resp_err(err[1]),
        .cos_theta(ct[1]), .cos_result(cr[1]), .busy(bsy[1]));

    function automatic int lat(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    // Stand-in cosine: exact for the directed points, a fixed scramble elsewhere.
    function automatic logic [31:0] core_fn(input logic [31:0] t);
        case (t)
            32'h0000_0000, 32'h8000_0000: return 32'h4000_0000;
            32'h3F80_0000, 32'hBF80_0000: return 32'h2294_5019;
            default:                      return {2'b00, t[29:0] ^ 30'h155A_A5C3};
        endcase
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_stub
        logic [31:0] last = 32'hFFFF_FFFF;
        int          sc   = 100;
        always @(posedge clk) begin
            #1;
            if (ct[k] !== last) begin
                last = ct[k];
                sc   = 0;
            end else if (sc < 100) begin
                sc++;
            end
        end
        assign cr[k] = (sc >= lat(k)) ? core_fn(ct[k]) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rv[k] = '0;
            rr[k] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_theta();
        case ($urandom % 4)
            0: return $urandom;
            1: return {1'($urandom), 8'($urandom_range(126, 0)), 23'($urandom)};
            2: case ($urandom % 7)
                   0: return 32'h3F80_0001;
                   1: return 32'h7F80_0000;
                   2: return 32'h7FC0_0000;
                   3: return 32'hFF80_0000;
                   4: return 32'h0000_0000;
                   5: return 32'h8000_0000;
                   default: return 32'h0000_0001;
               endcase
            default: return {1'($urandom), 31'h3F80_0000};
        endcase
    endfunction

    // Reference timeline: accepted requests finish their core wait after
    // LATENCY+1 cycles (0 for range errors), then respond until retired.
    task automatic rand_run(input int k, input int ncyc);
        int          mph  = 0;
        int          mcnt = 0;
        int          mid  = 0;
        int          mptr = 0;
        logic [31:0] mres = '0;
        logic        merr = 1'b0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            int          g;
            logic [1:0]  exp_rdy;
            logic [31:0] th;
            @(negedge clk);
            rv[k]  = 2'($urandom);
            rr[k]  = 2'($urandom);
            rth[k] = {rnd_theta(), rnd_theta()};
            #1;
            g = -1;
            if (mph == 0) begin
                for (int j = 0; j < 2; j++) begin
                    int cand = (mptr + j) % 2;
                    if (g < 0 && rv[k][cand]) g = cand;
                end
            end
            exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
            chk("rnd_req_ready", 32'(rdy[k]), 32'(exp_rdy));
            chk("rnd_busy", 32'(bsy[k]), (mph != 0) ? 1 : 0);
            if (mph == 2) begin
                chk("rnd_resp_valid", 32'(rsv[k]), 32'(1 << mid));
                chk("rnd_resp_result", res[k], mres);
                chk("rnd_resp_err", 32'(err[k]), 32'(merr));
            end else begin
                chk("rnd_resp_idle", 32'(rsv[k]), 0);
            end
            if (g >= 0) begin
                mid  = g;
                mptr = (g + 1) % 2;
                th   = (g == 0) ? rth[k][31:0] : rth[k][63:32];
                merr = ((th & 32'h7FFF_FFFF) > 32'h3F80_0000);
                mres = merr ? 32'h0 : core_fn(th);
                if (merr) begin
                    mph = 2;
                end else begin
                    mph  = 1;
                    mcnt = lat(k) + 1;
                end
            end else if (mph == 1) begin
                mcnt--;
                if (mcnt == 0) mph = 2;
            end else if (mph == 2 && rr[k][mid]) begin
                mph = 0;
            end
        end
        @(negedge clk);
        rv[k] = '0;
        rr[k] = 2'b11;
        repeat (8) @(negedge clk);
        rr[k] = '0;
    endtask

    typedef struct {
        logic [31:0] theta;
        logic        exp_err;
        logic [31:0] exp_res;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] prev;
        int          ng;
        int          lastc;

        tbl[0] = '{32'hBF80_0000, 1'b0, core_fn(32'hBF80_0000)};
        tbl[1] = '{32'h3F80_0001, 1'b1, 32'h0};
        tbl[2] = '{32'h4000_0000, 1'b1, 32'h0};
        tbl[3] = '{32'h7F80_0000, 1'b1, 32'h0};
        tbl[4] = '{32'h7FC0_0000, 1'b1, 32'h0};
        tbl[5] = '{32'h0000_0001, 1'b0, core_fn(32'h0000_0001)};
        tbl[6] = '{32'h8000_0000, 1'b0, 32'h4000_0000};
        tbl[7] = '{32'h3F7F_FFFF, 1'b0, core_fn(32'h3F7F_FFFF)};
        tbl[8] = '{32'hFF80_0000, 1'b1, 32'h0};

        for (int k = 0; k < 2; k++) begin
            rv[k] = '0; rr[k] = '0; rth[k] = '0;
        end
        do_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_cos_theta", ct[k], 0);
            chk("rst_result", res[k], 0);
            chk("rst_err", 32'(err[k]), 0);
            chk("rst_resp_valid", 32'(rsv[k]), 0);
            chk("rst_req_ready", 32'(rdy[k]), 0);
            chk("rst_busy", 32'(bsy[k]), 0);
        end

        // 1: LATENCY 0, theta 0
        @(negedge clk);
        rv[0] = 2'b01; rth[0] = 64'h0;
        #1 chk("t1_ready_c0", 32'(rdy[0]), 32'h1);
        @(negedge clk);
        rv[0] = '0;
        #1 chk("t1_cos_theta_c1", ct[0], 32'h0);
        chk("t1_busy_c1", 32'(bsy[0]), 1);
        chk("t1_no_resp_c1", 32'(rsv[0]), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("t1_resp_valid", 32'(rsv[0]), 32'h1);
            chk("t1_resp_result", res[0], 32'h4000_0000);
            chk("t1_resp_err", 32'(err[0]), 0);
        end
        @(negedge clk);
        rr[0] = 2'b01;
        @(negedge clk);
        rr[0] = '0;
        #1 chk("t1_retired", 32'(rsv[0]), 0);
        chk("t1_idle", 32'(bsy[0]), 0);

        // 2: LATENCY 3, requester 1, theta 1.0
        @(negedge clk);
        rv[1] = 2'b10; rth[1] = {32'h3F80_0000, 32'h0};
        #1 chk("t2_ready", 32'(rdy[1]), 32'h2);
        @(negedge clk);
        rv[1] = '0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1 chk("t2_wait_theta", ct[1], 32'h3F80_0000);
            chk("t2_wait_no_resp", 32'(rsv[1]), 0);
        end
        @(negedge clk);
        #1 chk("t2_resp_valid", 32'(rsv[1]), 32'h2);
        chk("t2_resp_result", res[1], 32'h2294_5019);
        chk("t2_resp_err", 32'(err[1]), 0);
        @(negedge clk);
        rr[1] = 2'b10;
        @(negedge clk);
        rr[1] = '0;

        // 3: both requesters continuously valid
        do_reset();
        rth[1] = {32'h3F00_0000, 32'h3E80_0000};
        rr[1]  = 2'b11;
        @(negedge clk);
        rv[1] = 2'b11;
        ng = 0;
        lastc = 0;
        for (int c = 0; c < 200 && ng < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bsy[1]) chk("t3_ready_outside_idle", 32'(rdy[1]), 0);
            if (rdy[1] != 2'b00) begin
                chk("t3_onehot", 32'($onehot(rdy[1])), 1);
                chk("t3_grant_order", 32'(rdy[1]), (ng % 2 == 0) ? 32'h1 : 32'h2);
                if (ng > 0) chk("t3_period", 32'(c - lastc), 32'(lat(1) + 3));
                lastc = c;
                ng++;
            end
        end
        chk("t3_grant_count", 32'(ng), 6);
        @(negedge clk);
        rv[1] = '0;
        repeat (8) @(negedge clk);
        rr[1] = '0;

        // 4: range table on LATENCY 3 instance, requester 0
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rr[1] = '0;
            rv[1] = 2'b01; rth[1] = {32'h0, tbl[i].theta};
            prev  = ct[1];
            #1 chk("t4_ready", 32'(rdy[1]), 32'h1);
            @(negedge clk);
            rv[1] = '0;
            #1;
            if (tbl[i].exp_err) begin
                chk("t4_err_resp_valid", 32'(rsv[1]), 32'h1);
                chk("t4_err_flag", 32'(err[1]), 1);
                chk("t4_err_result", res[1], 32'h0);
                chk("t4_err_theta_held", ct[1], prev);
            end else begin
                chk("t4_ok_theta", ct[1], tbl[i].theta);
                chk("t4_ok_wait", 32'(rsv[1]), 0);
                repeat (lat(1)) @(negedge clk);
                @(negedge clk);
                #1 chk("t4_ok_resp_valid", 32'(rsv[1]), 32'h1);
                chk("t4_ok_err", 32'(err[1]), 0);
                chk("t4_ok_result", res[1], tbl[i].exp_res);
            end
            @(negedge clk);
            rr[1] = 2'b01;
        end
        @(negedge clk);
        rr[1] = '0;

        // 5: reset during WAIT, then during RESP
        @(negedge clk);
        rv[1] = 2'b01; rth[1] = {32'h3E00_0000, 32'h3F00_0000};
        #1 chk("t5_ready", 32'(rdy[1]), 32'h1);
        @(negedge clk);
        rv[1] = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("t5_wait_rst_resp", 32'(rsv[1]), 0);
        chk("t5_wait_rst_busy", 32'(bsy[1]), 0);
        @(negedge clk);
        rv[1] = 2'b11;
        #1 chk("t5_ptr_zero", 32'(rdy[1]), 32'h1);
        @(negedge clk);
        rv[1] = '0;
        repeat (lat(1) + 1) @(negedge clk);
        #1 chk("t5_in_resp", 32'(rsv[1]), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("t5_resp_rst_resp", 32'(rsv[1]), 0);
        chk("t5_resp_rst_busy", 32'(bsy[1]), 0);
        chk("t5_resp_rst_result", res[1], 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 chk("t5_no_late_resp", 32'(rsv[1]), 0);
        end
        @(negedge clk);
        rv[1] = 2'b11;
        #1 chk("t5_ptr_zero_again", 32'(rdy[1]), 32'h1);
        @(negedge clk);
        rv[1] = '0;
        rr[1] = 2'b11;
        repeat (8) @(negedge clk);
        rr[1] = '0;

        // 6: resp_ready on the wrong index is ignored
        @(negedge clk);
        rv[1] = 2'b10; rth[1] = {32'h3F80_0000, 32'h0};
        #1 chk("t6_ready", 32'(rdy[1]), 32'h2);
        @(negedge clk);
        rv[1] = '0;
        repeat (lat(1) + 1) @(negedge clk);
        #1 chk("t6_in_resp", 32'(rsv[1]), 32'h2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rr[1] = 2'b01;
            #1 chk("t6_hold_valid", 32'(rsv[1]), 32'h2);
            chk("t6_hold_busy", 32'(bsy[1]), 1);
            chk("t6_hold_result", res[1], 32'h2294_5019);
        end
        @(negedge clk);
        rr[1] = 2'b10; rv[1] = 2'b01;
        #1 chk("t6_no_accept_in_resp", 32'(rdy[1]), 0);
        @(negedge clk);
        rr[1] = '0;
        #1 chk("t6_retired", 32'(rsv[1]), 0);
        chk("t6_next_accept", 32'(rdy[1]), 32'h1);
        @(negedge clk);
        rv[1] = '0;
        rr[1] = 2'b11;
        repeat (8) @(negedge clk);
        rr[1] = '0;

        rand_run(0, 1500);
        rand_run(1, 1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
